lsu_bus_port: RTL and testbench

- Load/store unit directly downstream of the execute-stage memory unit: consumes its lsu_* request interface and returns load data and faults.
- Performs one aligned 64-bit memory-bus transaction per request, with address-range and timeout fault detection.
- Strictly one request in flight; the core is already serialized around memory ops.

---
 rtl/basic_cache_params.sv | 7 +
 rtl/lsu_types.sv | 18 +
 rtl/lsu_timeout_counter.sv | 28 ++
 rtl/lsu_bus_port.sv | 142 ++++++++++++++
 tb/tb_lsu_bus_port.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/basic_cache_params.sv
// Address geometry shared by the cache and the load/store path.
package basic_cache_params;
   localparam int ALEN              = 32;
   localparam int XLEN              = 64;
   localparam int align_bits        = 3;
   localparam int aligned_addr_size = ALEN - align_bits;
endpackage

// File: rtl/lsu_types.sv
// State encoding and captured bus-request layout for the LSU bus port.
package lsu_types;
   import basic_cache_params::*;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP,
      ST_DONE
   } lsu_state_e;

   typedef struct packed {
      logic [ALEN-1:0]   addr;
      logic              write;
      logic [XLEN-1:0]   wdata;
      logic [XLEN/8-1:0] wmask;
   } bus_req_t;
endpackage

// File: rtl/lsu_timeout_counter.sv
// 8-bit saturating response-wait counter; expired flags the cycle whose count reaches LIMIT.
module lsu_timeout_counter #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam logic [8:0] LIMIT_W = 9'(LIMIT);

   logic [7:0] count;
   logic [8:0] count_inc;

   assign count_inc = {1'b0, count} + 9'd1;
   assign expired   = en && (count_inc >= LIMIT_W);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != 8'hFF)) begin
         count <= count + 8'd1;
      end
   end
endmodule

// File: rtl/lsu_bus_port.sv
// Single-outstanding load/store port: one aligned 64-bit bus transaction per request,
// with address-window and response-timeout faults.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; captures it and range-checks it
// REQ     | mem_req_valid held with captured request until ready
// RESP    | waiting for response beat; timeout counter running
// DONE    | one-cycle completion: stall_next low, data/fault presented
module lsu_bus_port
   import basic_cache_params::*;
   import lsu_types::*;
#(
   parameter logic [ALEN-1:0] MEM_BASE       = 32'h8000_0000,
   parameter logic [ALEN-1:0] MEM_SIZE       = 32'h1000_0000,
   parameter int unsigned     TIMEOUT_CYCLES = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         lsu_prev_stalled,
   output logic                         lsu_stall_next,
   input  logic [aligned_addr_size-1:0] lsu_addr,
   input  logic                         lsu_do_load,
   input  logic                         lsu_do_store,
   input  logic [XLEN-1:0]              lsu_store_data,
   input  logic [XLEN/8-1:0]            lsu_store_mask,
   output logic [XLEN-1:0]              lsu_load_data,
   output logic                         lsu_access_fault,
   output logic                         mem_req_valid,
   input  logic                         mem_req_ready,
   output logic [ALEN-1:0]              mem_req_addr,
   output logic                         mem_req_write,
   output logic [XLEN-1:0]              mem_req_wdata,
   output logic [XLEN/8-1:0]            mem_req_wmask,
   input  logic                         mem_resp_valid,
   input  logic [XLEN-1:0]              mem_resp_data,
   input  logic                         mem_resp_error
);
   if (align_bits != 3) begin : g_align_chk
      $error("lsu_bus_port assumes 8-byte lines (align_bits == 3)");
   end
   if (MEM_BASE[2:0] != 3'b000) begin : g_base_chk
      $error("lsu_bus_port: MEM_BASE must be 8-byte aligned");
   end
   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_tmo_chk
      $error("lsu_bus_port: TIMEOUT_CYCLES must be in 1..255");
   end

   // Window end computed one bit wider so BASE+SIZE at the top of the space cannot wrap.
   localparam logic [ALEN:0] LAST_ADDR =
      {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - (ALEN+1)'(8);

   lsu_state_e state;
   bus_req_t   req_q;
   logic       tmo_expired;

   logic [ALEN-1:0] byte_addr;
   logic            in_range;
   logic            is_write;

   assign byte_addr = {lsu_addr, {align_bits{1'b0}}};
   assign in_range  = (byte_addr >= MEM_BASE) && ({1'b0, byte_addr} <= LAST_ADDR);
   assign is_write  = lsu_do_store && !lsu_do_load;

   assign mem_req_addr  = req_q.addr;
   assign mem_req_write = req_q.write;
   assign mem_req_wdata = req_q.wdata;
   assign mem_req_wmask = req_q.wmask;

   lsu_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clr     (state != ST_RESP),
      .en      (state == ST_RESP),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= ST_IDLE;
         lsu_stall_next   <= 1'b1;
         lsu_access_fault <= 1'b0;
         lsu_load_data    <= '0;
         mem_req_valid    <= 1'b0;
         req_q            <= '0;
      end else begin
         lsu_stall_next <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (!lsu_prev_stalled) begin
                  req_q <= '{addr: byte_addr, write: is_write,
                             wdata: lsu_store_data, wmask: lsu_store_mask};
                  if (in_range) begin
                     state         <= ST_REQ;
                     mem_req_valid <= 1'b1;
                  end else begin
                     state            <= ST_DONE;
                     lsu_stall_next   <= 1'b0;
                     lsu_access_fault <= 1'b1;
                     lsu_load_data    <= '0;
                  end
               end
            end
            ST_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= ST_RESP;
               end
            end
            ST_RESP: begin
               // A response landing on the limit cycle takes priority over the timeout.
               if (mem_resp_valid) begin
                  state            <= ST_DONE;
                  lsu_stall_next   <= 1'b0;
                  lsu_access_fault <= mem_resp_error;
                  lsu_load_data    <= req_q.write ? '0 : mem_resp_data;
               end else if (tmo_expired) begin
                  state            <= ST_DONE;
                  lsu_stall_next   <= 1'b0;
                  lsu_access_fault <= 1'b1;
                  lsu_load_data    <= '0;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   a_req_only_idle: assert property (@(posedge clk) disable iff (!rst)
      !lsu_prev_stalled |-> (state == ST_IDLE));
   a_one_op: assert property (@(posedge clk) disable iff (!rst)
      !lsu_prev_stalled |-> (lsu_do_load ^ lsu_do_store));
`endif
endmodule

// File: tb/tb_lsu_bus_port.sv
// Directed bench for lsu_bus_port with a transaction-level timing/result model.
module tb_lsu_bus_port;
   import basic_cache_params::*;

   localparam int T = 4;

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         lsu_prev_stalled;
   logic                         lsu_stall_next;
   logic [aligned_addr_size-1:0] lsu_addr;
   logic                         lsu_do_load;
   logic                         lsu_do_store;
   logic [63:0]                  lsu_store_data;
   logic [7:0]                   lsu_store_mask;
   logic [63:0]                  lsu_load_data;
   logic                         lsu_access_fault;
   logic                         mem_req_valid;
   logic                         mem_req_ready;
   logic [31:0]                  mem_req_addr;
   logic                         mem_req_write;
   logic [63:0]                  mem_req_wdata;
   logic [7:0]                   mem_req_wmask;
   logic                         mem_resp_valid;
   logic [63:0]                  mem_resp_data;
   logic                         mem_resp_error;

   lsu_bus_port #(
      .MEM_BASE       (32'h8000_0000),
      .MEM_SIZE       (32'h1000_0000),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .lsu_prev_stalled (lsu_prev_stalled),
      .lsu_stall_next   (lsu_stall_next),
      .lsu_addr         (lsu_addr),
      .lsu_do_load      (lsu_do_load),
      .lsu_do_store     (lsu_do_store),
      .lsu_store_data   (lsu_store_data),
      .lsu_store_mask   (lsu_store_mask),
      .lsu_load_data    (lsu_load_data),
      .lsu_access_fault (lsu_access_fault),
      .mem_req_valid    (mem_req_valid),
      .mem_req_ready    (mem_req_ready),
      .mem_req_addr     (mem_req_addr),
      .mem_req_write    (mem_req_write),
      .mem_req_wdata    (mem_req_wdata),
      .mem_req_wmask    (mem_req_wmask),
      .mem_resp_valid   (mem_resp_valid),
      .mem_resp_data    (mem_resp_data),
      .mem_resp_error   (mem_resp_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction model: schedule and result derived from the request and bus behaviour.
   bit          txn_active = 1'b0;
   bit          chk_en = 1'b0;
   int          m_c, m_done, m_req_hi, m_rd, m_rsp, m_rlen;
   bit          m_inrange, m_write, m_fault, m_err;
   logic [31:0] m_addr;
   logic [63:0] m_wdata, m_data, m_rdata;
   logic [7:0]  m_wmask;

   int          done_pulses, req_cycles, last_done;
   logic [63:0] last_data;
   logic        last_fault;
   logic [31:0] last_req_addr;
   logic        e_done, e_req;

   always @(negedge clk) begin
      if (chk_en && rst) begin
         e_done = txn_active && (cyc == m_done);
         e_req  = txn_active && m_inrange && (cyc > m_c) && (cyc <= m_req_hi);
         chk("stall_next", {63'd0, lsu_stall_next}, {63'd0, !e_done});
         chk("mem_req_valid", {63'd0, mem_req_valid}, {63'd0, e_req});
         if (e_done && !lsu_stall_next) begin
            chk("load_data", lsu_load_data, m_data);
            chk("access_fault", {63'd0, lsu_access_fault}, {63'd0, m_fault});
         end
         if (e_req && mem_req_valid) begin
            chk("req_addr", {32'd0, mem_req_addr}, {32'd0, m_addr});
            chk("req_write", {63'd0, mem_req_write}, {63'd0, m_write});
            if (m_write) begin
               chk("req_wdata", mem_req_wdata, m_wdata);
               chk("req_wmask", {56'd0, mem_req_wmask}, {56'd0, m_wmask});
            end
         end
         if (!lsu_stall_next) begin
            done_pulses++;
            last_done  = cyc;
            last_data  = lsu_load_data;
            last_fault = lsu_access_fault;
         end
         if (mem_req_valid) begin
            req_cycles++;
            last_req_addr = mem_req_addr;
         end
      end
   end

   task automatic service();
      mem_req_ready  = m_inrange && (cyc >= m_c + 1 + m_rd);
      mem_resp_valid = m_inrange && (m_rsp != 0) && (cyc >= m_c + 1 + m_rd + m_rsp) &&
                       (cyc < m_c + 1 + m_rd + m_rsp + m_rlen);
      mem_resp_data  = mem_resp_valid ? m_rdata : 64'd0;
      mem_resp_error = mem_resp_valid && m_err;
   endtask

   task automatic launch(input logic [31:0] addr, input bit write, input logic [63:0] wdata,
                         input logic [7:0] wmask, input int rd, input int rsp, input int rlen,
                         input logic [63:0] rdata, input bit err);
      @(negedge clk);
      m_c = cyc; m_addr = addr; m_write = write; m_wdata = wdata; m_wmask = wmask;
      m_rd = rd; m_rsp = rsp; m_rlen = rlen; m_rdata = rdata; m_err = err;
      m_inrange = (addr >= 32'h8000_0000) && (addr <= 32'h8FFF_FFF8);
      if (!m_inrange) begin
         m_done = m_c + 1; m_req_hi = m_c; m_data = 64'd0; m_fault = 1'b1;
      end else begin
         m_req_hi = m_c + 1 + rd;
         if (rsp != 0 && rsp <= T) begin
            m_done = m_c + 2 + rd + rsp; m_data = write ? 64'd0 : rdata; m_fault = err;
         end else begin
            m_done = m_c + 2 + rd + T; m_data = 64'd0; m_fault = 1'b1;
         end
      end
      done_pulses = 0; req_cycles = 0; last_done = -1;
      txn_active = 1'b1;
      lsu_prev_stalled = 1'b0;
      lsu_addr       = addr[31:3];
      lsu_do_load    = !write;
      lsu_do_store   = write;
      lsu_store_data = wdata;
      lsu_store_mask = wmask;
      service();
   endtask

   task automatic finish_txn();
      while (cyc < m_done + 2) begin
         @(negedge clk);
         lsu_prev_stalled = 1'b1;
         service();
      end
      txn_active = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_error = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      lsu_prev_stalled = 1'b1; lsu_addr = '0; lsu_do_load = 1'b0; lsu_do_store = 1'b0;
      lsu_store_data = '0; lsu_store_mask = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_error = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_stall_next", {63'd0, lsu_stall_next}, 64'd1);
      chk("rst_fault", {63'd0, lsu_access_fault}, 64'd0);
      chk("rst_load_data", lsu_load_data, 64'd0);
      chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
      rst = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);

      // Plain load, 1-cycle memory
      launch(32'h8000_0010, 1'b0, 64'd0, 8'h00, 0, 1, 1, 64'h1122_3344_5566_7788, 1'b0);
      finish_txn();
      chk("t1_latency", 64'(last_done - m_c), 64'd3);
      chk("t1_data", last_data, 64'h1122_3344_5566_7788);
      chk("t1_fault", {63'd0, last_fault}, 64'd0);
      chk("t1_req_addr", {32'd0, last_req_addr}, 64'h8000_0010);
      chk("t1_pulses", 64'(done_pulses), 64'd1);

      // Store with ready held low 3 cycles
      launch(32'h8000_0008, 1'b1, 64'hABAB_ABAB_ABAB_ABAB, 8'h02, 3, 1, 1, 64'hDEAD, 1'b0);
      finish_txn();
      chk("t2_req_cycles", 64'(req_cycles), 64'd4);
      chk("t2_pulses", 64'(done_pulses), 64'd1);
      chk("t2_latency", 64'(last_done - m_c), 64'd6);
      chk("t2_fault", {63'd0, last_fault}, 64'd0);
      chk("t2_data", last_data, 64'd0);

      // Just below the window
      launch(32'h7FFF_FFF8, 1'b0, 64'd0, 8'h00, 0, 1, 1, 64'h1, 1'b0);
      finish_txn();
      chk("t3_req_cycles", 64'(req_cycles), 64'd0);
      chk("t3_latency", 64'(last_done - m_c), 64'd1);
      chk("t3_fault", {63'd0, last_fault}, 64'd1);
      chk("t3_data", last_data, 64'd0);

      // Last legal line, ready after 1 cycle, response on 2nd RESP cycle
      launch(32'h8FFF_FFF8, 1'b0, 64'd0, 8'h00, 1, 2, 1, 64'h0102_0304_0506_0708, 1'b0);
      finish_txn();
      chk("t4_latency", 64'(last_done - m_c), 64'd5);
      chk("t4_fault", {63'd0, last_fault}, 64'd0);

      // Just past the window
      launch(32'h9000_0000, 1'b1, 64'h5A5A, 8'hFF, 0, 1, 1, 64'h0, 1'b0);
      finish_txn();
      chk("t5_req_cycles", 64'(req_cycles), 64'd0);
      chk("t5_fault", {63'd0, last_fault}, 64'd1);

      // Timeout, then a late response across DONE and IDLE
      launch(32'h8000_0020, 1'b0, 64'd0, 8'h00, 0, T + 1, 2, 64'h5555_5555_5555_5555, 1'b0);
      finish_txn();
      chk("t6_latency", 64'(last_done - m_c), 64'd6);
      chk("t6_fault", {63'd0, last_fault}, 64'd1);
      chk("t6_data", last_data, 64'd0);
      chk("t6_pulses", 64'(done_pulses), 64'd1);

      // Response on the limit cycle beats the timeout
      launch(32'h8000_0028, 1'b0, 64'd0, 8'h00, 0, T, 1, 64'h0BAD_F00D_1234_5678, 1'b0);
      finish_txn();
      chk("t7_latency", 64'(last_done - m_c), 64'd6);
      chk("t7_fault", {63'd0, last_fault}, 64'd0);
      chk("t7_data", last_data, 64'h0BAD_F00D_1234_5678);

      // Bus error on a load
      launch(32'h8000_0030, 1'b0, 64'd0, 8'h00, 0, 1, 1, 64'hCAFE_BABE_0000_1234, 1'b1);
      finish_txn();
      chk("t8_fault", {63'd0, last_fault}, 64'd1);
      chk("t8_data", last_data, 64'hCAFE_BABE_0000_1234);

      // Reset while waiting in RESP
      launch(32'h8000_0100, 1'b0, 64'd0, 8'h00, 0, 0, 1, 64'h0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         lsu_prev_stalled = 1'b1;
         service();
      end
      chk_en = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("t9_stall_next", {63'd0, lsu_stall_next}, 64'd1);
      chk("t9_fault", {63'd0, lsu_access_fault}, 64'd0);
      chk("t9_load_data", lsu_load_data, 64'd0);
      chk("t9_req_valid", {63'd0, mem_req_valid}, 64'd0);
      txn_active = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_error = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      // Normal load after reset
      launch(32'h8000_0040, 1'b0, 64'd0, 8'h00, 0, 1, 1, 64'h7766_5544_3322_1100, 1'b0);
      finish_txn();
      chk("t10_latency", 64'(last_done - m_c), 64'd3);
      chk("t10_data", last_data, 64'h7766_5544_3322_1100);
      chk("t10_fault", {63'd0, last_fault}, 64'd0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
